// File: rtl/hilo_ctrl.sv
// HI/LO register file and mult/div sequencer: latches operands, holds the
// pipeline while the iterative unit runs, and captures its 64-bit result.
module hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_mult,
  input  logic        op_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] value_A_Mc,
  output logic [31:0] value_B_Mp,
  output logic        multInit,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_done,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        divInit,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        div_zero,
  output logic        timeout_err
);

  // state     | meaning
  // IDLE      | accepting issues and mthi/mtlo
  // MULT_WAIT | multiplier running, waiting for mult_done
  // DIV_WAIT  | divider running, waiting for div_done
  typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_WAIT} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   mc_q, mc_d, mp_q, mp_d;
  logic [31:0]   da_q, da_d, db_q, db_d;
  logic          mult_init_q, mult_init_d;
  logic          div_init_q, div_init_d;
  logic          div_zero_q, div_zero_d;
  logic          tmo_q, tmo_d;
  logic          last_wait;

  assign last_wait = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    da_d        = da_q;
    db_d        = db_q;
    mult_init_d = mult_init_q;
    div_init_d  = div_init_q;
    div_zero_d  = 1'b0;
    tmo_d       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi) hi_d = op_a;
        if (mtlo) lo_d = op_a;
        // multiply takes precedence; a simultaneous divide is silently dropped
        if (op_mult) begin
          mc_d        = op_a;
          mp_d        = op_b;
          cnt_d       = '0;
          mult_init_d = 1'b1;
          state_d     = MULT_WAIT;
          stall       = 1'b1;
        end else if (op_div) begin
          if (op_b != 32'd0) begin
            da_d       = op_a;
            db_d       = op_b;
            cnt_d      = '0;
            div_init_d = 1'b1;
            state_d    = DIV_WAIT;
            stall      = 1'b1;
          end else begin
            div_zero_d = 1'b1;
          end
        end
      end
      MULT_WAIT: begin
        stall = 1'b1;
        if (mult_done) begin
          hi_d        = mult_hi;
          lo_d        = mult_lo;
          mult_init_d = 1'b0;
          state_d     = IDLE;
        end else if (last_wait) begin
          tmo_d       = 1'b1;
          mult_init_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV_WAIT: begin
        stall = 1'b1;
        if (div_done) begin
          hi_d       = div_hi;
          lo_d       = div_lo;
          div_init_d = 1'b0;
          state_d    = IDLE;
        end else if (last_wait) begin
          tmo_d      = 1'b1;
          div_init_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        mult_init_d = 1'b0;
        div_init_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      da_q        <= '0;
      db_q        <= '0;
      mult_init_q <= 1'b0;
      div_init_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      da_q        <= da_d;
      db_q        <= db_d;
      mult_init_q <= mult_init_d;
      div_init_q  <= div_init_d;
      div_zero_q  <= div_zero_d;
      tmo_q       <= tmo_d;
    end
  end

  assign value_A_Mc  = mc_q;
  assign value_B_Mp  = mp_q;
  assign div_a       = da_q;
  assign div_b       = db_q;
  assign multInit    = mult_init_q;
  assign divInit     = div_init_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_zero    = div_zero_q;
  assign timeout_err = tmo_q;

endmodule
